id_fwd_queue: RTL and testbench
===============================

ID_FWD_QUEUE -- requirements
Module: id_fwd_queue

Interface
REQ-001 Parameters SHALL be: W, default 32, datapath width; RA, default 5, register-address width; NFWD, default 3, forward channel count (>=1); DEPTH, default 2, queue depth (power of 2, >=2); CW, default 16, opaque control-word width.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 clock, rising edge; reset in 1 synchronous, active-high.
REQ-003 flush in 1 discard all queued entries and block acceptance this cycle.
REQ-004 in_valid in 1, in_ready out 1: decoded-instruction handshake; in_pc in W; in_ctrl in CW; in_br_op in 3; in_rs_addr, in_rt_addr in RA.
REQ-005 grf_rs, grf_rt in W: register-file read data for in_rs_addr/in_rt_addr.
REQ-006 fwd_addr in NFWD*RA, fwd_data in NFWD*W, fwd_vld in NFWD: per-channel pending write (channel 0 youngest, highest priority); fwd_vld=0 means address is claimed but data not yet produced.
REQ-007 br_taken out 1: branch decision for the instruction accepted this cycle.
REQ-008 out_valid out 1, out_ready in 1: head-of-queue handshake; out_pc out W; out_ctrl out CW; out_rs_addr, out_rt_addr out RA; out_rs, out_rt out W.

Function
REQ-009 Operand resolution (per operand, combinational): address 0 SHALL yield 0; else lowest-index channel with fwd_addr==operand address SHALL supply fwd_data; no match SHALL yield grf value.
REQ-010 Operand hazard SHALL be asserted when the selected matching channel has fwd_vld=0; lower-priority valid matches SHALL NOT override it.
REQ-011 in_ready SHALL equal (count != DEPTH) & ~hazard_rs & ~hazard_rt & ~flush; it SHALL NOT depend on out_ready (no pass-through when full).
REQ-012 Push SHALL occur when in_valid & in_ready; entry stores pc, ctrl, addrs and resolved operand values, which SHALL never be re-resolved later.
REQ-013 Pop SHALL occur when out_valid & out_ready & ~flush.
REQ-014 count SHALL update +1 on push only, -1 on pop only, unchanged on both or neither; read/write pointers SHALL wrap modulo DEPTH.
REQ-015 out_valid SHALL equal (count != 0); when count==0 all out_* data SHALL be 0.
REQ-016 Latency: entry pushed at edge k into empty queue SHALL appear on out_* with out_valid=1 after edge k; order SHALL be strictly FIFO.
REQ-017 br_op encoding: 0 none, 1 beq (rs==rt), 2 bne (rs!=rt), 3 bgez (rs[W-1]==0), 4 bgtz (rs[W-1]==0 & rs!=0), 5 blez (rs[W-1]==1 | rs==0), 6 bltz (rs[W-1]==1), 7 reserved = not taken; all on resolved operands.
REQ-018 br_taken SHALL be compare result AND push; 0 on any non-pushing cycle.
REQ-019 flush SHALL set count and pointers to 0 at the next edge, overriding simultaneous push and pop.

Reset
REQ-020 On reset at a rising edge: count=0, pointers=0, out_valid=0, all out_* data=0, storage contents irrelevant; reset SHALL override flush, push and pop.
REQ-021 Reset asserted mid-operation SHALL drop all entries; in_ready SHALL read 1 in the first post-reset cycle absent hazards.

Verification
REQ-022 fwd ch0 addr=8 data=0x11 vld=1, ch1 addr=8 data=0x22 vld=1, in_rs_addr=8, grf_rs=0x33 -> entry out_rs=0x11; in_rs_addr=0 with ch0 addr=0 -> out_rs=0.
REQ-023 ch0 addr=9 vld=0, ch1 addr=9 vld=1, in_rt_addr=9, in_valid=1 -> in_ready=0, no push, br_taken=0; next cycle ch0 vld=1 data=0x5 -> push, out_rt=0x5.
REQ-024 DEPTH=2, out_ready=0, push pc 0x3000, 0x3004 -> in_ready=0 thereafter; third in_valid held; raise out_ready -> pops 0x3000 then 0x3004, third pushed after first pop, order preserved across pointer wrap.
REQ-025 br_op=3, rs=0x8000_0000 -> br_taken=0; br_op=6 same rs -> 1; br_op=4, rs=0 -> 0; br_op=5, rs=0 -> 1; br_op=1, rs=rt=0x7 -> 1.
REQ-026 count=1, same cycle in_valid, out_ready and flush=1 -> in_ready=0, br_taken=0, next cycle out_valid=0, out_pc=0.
REQ-027 count=2 with reset and in_valid=1 same edge -> next cycle count=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/id_fwd_queue.sv
// id_fwd_queue: decode-stage operand resolution plus a small in-order issue queue.
//   Each incoming instruction's rs/rt operands are resolved against NFWD pending
//   writes (channel 0 youngest, highest priority) or the register file. The
//   resolved values are captured in the queue. A branch decision is produced
//   only for the instruction that is accepted in the current cycle.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   flush                 drop all queued entries, refuse input this cycle
//   in_valid/in_ready     input handshake; in_pc, in_ctrl, in_br_op, in_rs/rt_addr
//   grf_rs, grf_rt        register-file read data for in_rs_addr/in_rt_addr
//   fwd_addr/data/vld     per-channel pending writes (vld=0: data not ready yet)
//   br_taken              branch outcome for the instruction pushed this cycle
//   out_valid/out_ready   head-of-queue handshake; out_pc, out_ctrl, out_rs/rt_addr, out_rs/rt
module id_fwd_queue #(
  parameter int W     = 32,
  parameter int RA    = 5,
  parameter int NFWD  = 3,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_pc,
  input  logic [CW-1:0]      in_ctrl,
  input  logic [2:0]         in_br_op,
  input  logic [RA-1:0]      in_rs_addr,
  input  logic [RA-1:0]      in_rt_addr,
  input  logic [W-1:0]       grf_rs,
  input  logic [W-1:0]       grf_rt,
  input  logic [NFWD*RA-1:0] fwd_addr,
  input  logic [NFWD*W-1:0]  fwd_data,
  input  logic [NFWD-1:0]    fwd_vld,
  output logic               br_taken,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_pc,
  output logic [CW-1:0]      out_ctrl,
  output logic [RA-1:0]      out_rs_addr,
  output logic [RA-1:0]      out_rt_addr,
  output logic [W-1:0]       out_rs,
  output logic [W-1:0]       out_rt
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  logic [CNTW-1:0] r_cnt;
  logic [PW-1:0]   r_wp, r_rp;

  logic [W-1:0]  r_pc  [DEPTH];
  logic [CW-1:0] r_ctrl[DEPTH];
  logic [RA-1:0] r_rsa [DEPTH];
  logic [RA-1:0] r_rta [DEPTH];
  logic [W-1:0]  r_rs  [DEPTH];
  logic [W-1:0]  r_rt  [DEPTH];

  logic [W-1:0] w_rs, w_rt;
  logic         w_hz_rs, w_hz_rt;
  logic         w_cmp, w_push, w_pop;

  // Walk channels from lowest priority to highest so the lowest-index match
  // is the last assignment. The hazard follows the selected channel only,
  // so a lower-priority valid match never masks a pending younger write.
  always_comb begin
    w_rs    = grf_rs;
    w_rt    = grf_rt;
    w_hz_rs = 1'b0;
    w_hz_rt = 1'b0;
    for (int c = NFWD-1; c >= 0; c--) begin
      if (fwd_addr[c*RA +: RA] == in_rs_addr) begin
        w_rs    = fwd_data[c*W +: W];
        w_hz_rs = ~fwd_vld[c];
      end
      if (fwd_addr[c*RA +: RA] == in_rt_addr) begin
        w_rt    = fwd_data[c*W +: W];
        w_hz_rt = ~fwd_vld[c];
      end
    end
    // Register 0 is hard-wired zero and never waits on a producer.
    if (in_rs_addr == '0) begin
      w_rs    = '0;
      w_hz_rs = 1'b0;
    end
    if (in_rt_addr == '0) begin
      w_rt    = '0;
      w_hz_rt = 1'b0;
    end
  end

  always_comb begin
    w_cmp = 1'b0;
    case (in_br_op)
      3'd1:    w_cmp = (w_rs == w_rt);
      3'd2:    w_cmp = (w_rs != w_rt);
      3'd3:    w_cmp = ~w_rs[W-1];
      3'd4:    w_cmp = ~w_rs[W-1] & (w_rs != '0);
      3'd5:    w_cmp = w_rs[W-1] | (w_rs == '0);
      3'd6:    w_cmp = w_rs[W-1];
      default: w_cmp = 1'b0;
    endcase
  end

  assign in_ready  = (r_cnt != CNTW'(DEPTH)) & ~w_hz_rs & ~w_hz_rt & ~flush;
  assign w_push    = in_valid & in_ready;
  assign out_valid = (r_cnt != '0);
  assign w_pop     = out_valid & out_ready & ~flush;
  assign br_taken  = w_cmp & w_push;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_cnt <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
    end else begin
      if (w_push) r_wp <= PW'(r_wp + 1'b1);
      if (w_pop)  r_rp <= PW'(r_rp + 1'b1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= CNTW'(r_cnt + 1'b1);
        2'b01:   r_cnt <= CNTW'(r_cnt - 1'b1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage has no reset; an entry is only visible once counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wp]   <= in_pc;
      r_ctrl[r_wp] <= in_ctrl;
      r_rsa[r_wp]  <= in_rs_addr;
      r_rta[r_wp]  <= in_rt_addr;
      r_rs[r_wp]   <= w_rs;
      r_rt[r_wp]   <= w_rt;
    end
  end

  assign out_pc      = out_valid ? r_pc[r_rp]   : '0;
  assign out_ctrl    = out_valid ? r_ctrl[r_rp] : '0;
  assign out_rs_addr = out_valid ? r_rsa[r_rp]  : '0;
  assign out_rt_addr = out_valid ? r_rta[r_rp]  : '0;
  assign out_rs      = out_valid ? r_rs[r_rp]   : '0;
  assign out_rt      = out_valid ? r_rt[r_rp]   : '0;
endmodule

// File: tb/tb_id_fwd_queue.sv
// Scoreboard bench for id_fwd_queue: the stimulus side predicts accept/branch
// outcomes and queues expected entries; a negedge monitor checks the head.
module tb_id_fwd_queue;
  localparam int W = 32, RA = 5, NFWD = 3, DEPTH = 2, CW = 16;

  typedef struct {
    logic [W-1:0]  pc;
    logic [CW-1:0] ctrl;
    logic [RA-1:0] rsa;
    logic [RA-1:0] rta;
    logic [W-1:0]  rs;
    logic [W-1:0]  rt;
  } ent_t;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, br_taken, out_valid, out_ready;
  logic [W-1:0] in_pc, grf_rs, grf_rt, out_pc, out_rs, out_rt;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [2:0] in_br_op;
  logic [RA-1:0] in_rs_addr, in_rt_addr, out_rs_addr, out_rt_addr;
  logic [NFWD*RA-1:0] fwd_addr;
  logic [NFWD*W-1:0]  fwd_data;
  logic [NFWD-1:0]    fwd_vld;

  logic [RA-1:0] fa[NFWD];
  logic [W-1:0]  fd[NFWD];
  logic          fv[NFWD];

  always_comb begin
    fwd_addr = '0;
    fwd_data = '0;
    fwd_vld  = '0;
    for (int c = 0; c < NFWD; c++) begin
      fwd_addr[c*RA +: RA] = fa[c];
      fwd_data[c*W +: W]   = fd[c];
      fwd_vld[c]           = fv[c];
    end
  end

  always #5 clk = ~clk;

  id_fwd_queue #(.W(W), .RA(RA), .NFWD(NFWD), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ctrl(in_ctrl),
    .in_br_op(in_br_op), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .grf_rs(grf_rs), .grf_rt(grf_rt),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_vld(fwd_vld),
    .br_taken(br_taken), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ctrl(out_ctrl), .out_rs_addr(out_rs_addr),
    .out_rt_addr(out_rt_addr), .out_rs(out_rs), .out_rt(out_rt)
  );

  int   n_tests = 0, n_fail = 0;
  bit   mon_en = 0;
  ent_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference operand lookup: r0 reads zero, otherwise the first channel in
  // priority order holding the address supplies it, else the register file.
  function automatic logic [W-1:0] resolve(input logic [RA-1:0] a, input logic [W-1:0] g,
                                           output bit hz);
    hz = 0;
    if (a == 0) return '0;
    for (int c = 0; c < NFWD; c++)
      if (fa[c] == a) begin
        hz = !fv[c];
        return fd[c];
      end
    return g;
  endfunction

  function automatic bit branch(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    case (op)
      3'd1:    return rs == rt;
      3'd2:    return rs != rt;
      3'd3:    return $signed(rs) >= 0;
      3'd4:    return $signed(rs) > 0;
      3'd5:    return $signed(rs) <= 0;
      3'd6:    return $signed(rs) < 0;
      default: return 0;
    endcase
  endfunction

  // Called with inputs set shortly after a rising edge; predicts this cycle's
  // accept/branch outcome, then applies the queue update at the next edge.
  task automatic step();
    bit   hs, ht, rdy, push;
    ent_t e;
    #1;
    e.pc = in_pc; e.ctrl = in_ctrl; e.rsa = in_rs_addr; e.rta = in_rt_addr;
    e.rs = resolve(in_rs_addr, grf_rs, hs);
    e.rt = resolve(in_rt_addr, grf_rt, ht);
    rdy  = (q.size() < DEPTH) && !hs && !ht && !flush;
    push = in_valid && rdy;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("br_taken", 64'(br_taken), 64'(push && branch(in_br_op, e.rs, e.rt)));
    @(posedge clk);
    if (reset || flush) q.delete();
    else if (push) q.push_back(e);
    #1;
  endtask

  // Monitor: checks the head against the scoreboard and retires on pop.
  always @(negedge clk) begin
    if (mon_en) begin
      ent_t h;
      h = '{default: '0};
      if (q.size() != 0) h = q[0];
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("out_pc", 64'(out_pc), 64'(h.pc));
      chk("out_ctrl", 64'(out_ctrl), 64'(h.ctrl));
      chk("out_addrs", 64'({out_rs_addr, out_rt_addr}), 64'({h.rsa, h.rta}));
      chk("out_rs", 64'(out_rs), 64'(h.rs));
      chk("out_rt", 64'(out_rt), 64'(h.rt));
      if (q.size() != 0 && out_ready && !flush && !reset) void'(q.pop_front());
    end
  end

  task automatic idle();
    flush = 0; in_valid = 0; out_ready = 0; in_br_op = 0;
    in_pc = '0; in_ctrl = '0; in_rs_addr = '0; in_rt_addr = '0;
    grf_rs = '0; grf_rt = '0;
    for (int c = 0; c < NFWD; c++) begin fa[c] = 5'd31; fd[c] = '0; fv[c] = 1; end
  endtask

  task automatic drain();
    idle();
    out_ready = 1;
    repeat (3) step();
    out_ready = 0;
  endtask

  task automatic br(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    idle();
    out_ready = 1; in_valid = 1; in_br_op = op;
    in_rs_addr = 5'd1; in_rt_addr = 5'd2; grf_rs = rs; grf_rt = rt;
    in_pc = 32'h100 + 32'(op);
    step();
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    mon_en = 1;

    // Priority forwarding and r0
    idle();
    fa[0] = 8; fd[0] = 32'h11; fa[1] = 8; fd[1] = 32'h22;
    in_valid = 1; in_rs_addr = 8; grf_rs = 32'h33; in_pc = 32'h2000; in_ctrl = 16'hA5;
    step();
    fa[0] = 0; fd[0] = 32'h44; in_rs_addr = 0; in_pc = 32'h2004;
    step();
    drain();

    // Hazard on the highest-priority match stalls, then resolves
    idle();
    fa[0] = 9; fv[0] = 0; fa[1] = 9; fd[1] = 32'h77; in_rt_addr = 9; in_valid = 1;
    in_br_op = 3'd2; in_pc = 32'h2100;
    step();
    fv[0] = 1; fd[0] = 32'h5;
    step();
    drain();

    // Full queue, no pass-through, order across pointer wrap
    idle();
    in_valid = 1; in_pc = 32'h3000; step();
    in_pc = 32'h3004; step();
    in_pc = 32'h3008; step(); step();
    out_ready = 1;
    repeat (4) step();
    drain();

    // Branch encodings
    br(3'd3, 32'h8000_0000, 0);
    br(3'd6, 32'h8000_0000, 0);
    br(3'd4, 0, 0);
    br(3'd5, 0, 0);
    br(3'd1, 7, 7);
    br(3'd7, 7, 7);
    drain();

    // Flush with one entry, concurrent in_valid and out_ready
    idle();
    in_valid = 1; in_pc = 32'h4000; step();
    out_ready = 1; flush = 1; in_pc = 32'h4004; step();
    idle(); step();

    // Reset with a full queue and in_valid
    idle();
    in_valid = 1; in_pc = 32'h5000; step();
    in_pc = 32'h5004; step();
    reset = 1; in_pc = 32'h5008; step();
    reset = 0; idle(); step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(1) != 0);
      flush     = ($urandom_range(19) == 0);
      in_pc     = $urandom; in_ctrl = 16'($urandom);
      in_br_op  = 3'($urandom);
      in_rs_addr = 5'($urandom_range(3)); in_rt_addr = 5'($urandom_range(3));
      grf_rs = ($urandom_range(3) == 0) ? 32'h8000_0000 : 32'($urandom_range(3));
      grf_rt = ($urandom_range(1) == 0) ? grf_rs : $urandom;
      for (int c = 0; c < NFWD; c++) begin
        fa[c] = 5'($urandom_range(4));
        fd[c] = ($urandom_range(1) == 0) ? 32'($urandom_range(2)) : $urandom;
        fv[c] = ($urandom_range(4) != 0);
      end
      step();
    end

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
